// File: rtl/ship_position_ctrl.sv
// rtl/ship_position_ctrl.sv - player-ship position controller with hold-to-repeat and LED overlay
//
// Purpose:
//   Turns synchronized left/right key levels into a horizontal ship position.
//   A fresh press moves once immediately. Holding the key moves again after
//   HOLD_DLY cycles, and then every RPT_DLY cycles after that. The ship stops
//   at the edges, or wraps when WRAP=1. EN=0 pauses all movement. The ship is
//   drawn as a red-pixel overlay for the display compositor.
//
// Ports:
//   CLK        in   1                     system clock
//   RST        in   1                     synchronous, active-high reset
//   EN         in   1                     1 = movement enabled, 0 = paused
//   L          in   1                     left key level (already synchronized)
//   R          in   1                     right key level (already synchronized)
//   Pos        out  PW                    ship position, 0 = far left
//   Moved      out  1                     one-cycle pulse the cycle after Pos changes
//   RedPixels  out  [ROWS-1:0][COLS-1:0]  ship overlay, [row][col], row 0 = bottom

module ship_position_ctrl #(
  parameter int COLS     = 16,
  parameter int ROWS     = 16,
  parameter int SHIP_W   = 4,
  parameter int HOLD_DLY = 8,
  parameter int RPT_DLY  = 4,
  parameter int WRAP     = 0
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   EN,
  input  logic                                   L,
  input  logic                                   R,
  output logic [$clog2(COLS-SHIP_W+1)-1:0]       Pos,
  output logic                                   Moved,
  output logic [ROWS-1:0][COLS-1:0]              RedPixels
);

  localparam int NPOS   = COLS - SHIP_W + 1;
  localparam int PW     = $clog2(NPOS);
  localparam int CENTER = (COLS - SHIP_W) / 2;
  localparam int MAXD   = (HOLD_DLY > RPT_DLY) ? HOLD_DLY : RPT_DLY;
  localparam int CW     = $clog2(MAXD + 1);

  localparam logic [PW-1:0] LAST_POS   = PW'(NPOS - 1);
  localparam logic [PW-1:0] CENTER_POS = PW'(CENTER);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_DLY - 1);
  localparam logic [CW-1:0] RPT_LAST   = CW'(RPT_DLY - 1);

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  dir_e          dir;
  dir_e          prev_dir_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          moved_q;
  logic          do_move;
  logic          press;
  int            pos_int;

  // Both keys down counts as no direction, so neither key wins.
  always_comb begin
    dir = DIR_NONE;
    if (L && !R) begin
      dir = DIR_LEFT;
    end else if (R && !L) begin
      dir = DIR_RIGHT;
    end
  end

  // A press is any change into a real direction. This covers a direct L->R
  // swap and letting go of one key of a held pair.
  assign press = (dir != DIR_NONE) && (dir != prev_dir_q);

  // Repeat timing. cnt counts the cycles spent in the current HOLD or REPEAT
  // interval. A move happens on the cycle it reaches the interval's last value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    do_move = 1'b0;
    if (!EN || (dir == DIR_NONE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (press) begin
      do_move = 1'b1;
      state_d = ST_HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            do_move = 1'b1;
            state_d = ST_REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_REPEAT: begin
          if (cnt_q == RPT_LAST) begin
            do_move = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          // A key held across a pause stays here until it is released and
          // pressed again, because prev_dir already matches it.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Position update. A move blocked at an edge leaves pos_d == pos_q, so it
  // produces no Moved pulse. Repeat timing carries on regardless.
  always_comb begin
    pos_d = pos_q;
    if (do_move) begin
      if (dir == DIR_LEFT) begin
        if (pos_q != '0) begin
          pos_d = pos_q - PW'(1);
        end else if (WRAP != 0) begin
          pos_d = LAST_POS;
        end
      end else if (dir == DIR_RIGHT) begin
        if (pos_q != LAST_POS) begin
          pos_d = pos_q + PW'(1);
        end else if (WRAP != 0) begin
          pos_d = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pos_q      <= CENTER_POS;
      moved_q    <= 1'b0;
      prev_dir_q <= DIR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      moved_q    <= (pos_d != pos_q);
      prev_dir_q <= dir;
    end
  end

  assign Pos     = pos_q;
  assign Moved   = moved_q;
  assign pos_int = int'(pos_q);

  // Ship shape: a SHIP_W-wide base on row 0 and a two-pixel nose centred
  // above it on row 1.
  always_comb begin
    RedPixels = '0;
    for (int c = 0; c < COLS; c++) begin
      if ((c >= pos_int) && (c < pos_int + SHIP_W)) begin
        RedPixels[0][c] = 1'b1;
      end
      if ((c == pos_int + SHIP_W / 2 - 1) || (c == pos_int + SHIP_W / 2)) begin
        RedPixels[1][c] = 1'b1;
      end
    end
  end

endmodule
